game_regfile: RTL and testbench

- Parametrised second-generation processor register file for the game datapath: 2 read ports, 1 write port.
- Supports hardware-owned registers that are refreshed every cycle from game peripherals.
- Supports "slot" registers whose low field is allocated automatically and uniquely by a fair round-robin allocator.
- Has a watched register with a change strobe for the score display.
- Sits between the decode/writeback stages and the game I/O (button pad, target hit sensors, timers, score display).

---
 rtl/game_regfile_pkg.sv | 32 +++
 rtl/game_regfile_slot_allocator.sv | 53 +++++
 rtl/game_regfile.sv | 163 ++++++++++++++++
 tb/tb_game_regfile.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_regfile_pkg.sv
// Shared constants for the game register file, the I/O controller and the assembler headers.
package game_regfile_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ADDR_WIDTH = 5;

   // Registers 1,2,3,6,7,8 are refreshed from the game peripherals.
   localparam logic [31:0] DEF_HW_MASK = 32'h0000_01CE;

   // Slot registers and the id range handed out by the allocator.
   localparam int unsigned DEF_SLOT_BASE = 4;
   localparam int unsigned DEF_NUM_SLOTS = 2;
   localparam int unsigned SLOT_W        = 4;
   localparam int unsigned DEF_SLOT_MIN  = 4;
   localparam int unsigned DEF_SLOT_MAX  = 9;

   // Register mirrored to the score display.
   localparam int unsigned DEF_WATCH_ADDR = 9;

   typedef logic [SLOT_W-1:0] slot_id_t;

   // Next round-robin start point after a grant, wrapping past the top id.
   function automatic slot_id_t rr_advance(input slot_id_t grant,
                                           input int unsigned slot_min,
                                           input int unsigned slot_max);
      if (grant == SLOT_W'(slot_max)) begin
         return SLOT_W'(slot_min);
      end
      return grant + SLOT_W'(1);
   endfunction

endpackage

// File: rtl/game_regfile_slot_allocator.sv
// Combinational round-robin slot id allocator: picks the first free id at or
// after rr_ptr, wrapping to the bottom of the range.
module game_regfile_slot_allocator
   import game_regfile_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
   parameter int unsigned SLOT_MIN  = DEF_SLOT_MIN,
   parameter int unsigned SLOT_MAX  = DEF_SLOT_MAX
) (
   input  logic [NUM_SLOTS*SLOT_W-1:0] slot_fields,
   input  logic [NUM_SLOTS-1:0]        field_valid,
   input  slot_id_t                    rr_ptr,
   output logic                        grant_valid,
   output slot_id_t                    grant_id
);

   localparam int unsigned NUM_IDS = SLOT_MAX - SLOT_MIN + 1;

   logic [NUM_IDS-1:0] taken;
   logic [NUM_IDS-1:0] free_hi;
   logic [NUM_IDS-1:0] free_lo;

   // Mark every id currently held by a participating slot field.
   for (genvar j = 0; j < NUM_IDS; j++) begin : g_id
      logic [NUM_SLOTS-1:0] hit;
      for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
         assign hit[s] = field_valid[s] &&
                         (slot_fields[s*SLOT_W +: SLOT_W] == SLOT_W'(SLOT_MIN + j));
      end
      assign taken[j]   = |hit;
      assign free_hi[j] = !taken[j] && (SLOT_W'(SLOT_MIN + j) >= rr_ptr);
      assign free_lo[j] = !taken[j] && (SLOT_W'(SLOT_MIN + j) <  rr_ptr);
   end

   // Lowest free id at/after rr_ptr first, otherwise lowest free id below it.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = SLOT_W'(SLOT_MIN);
      for (int unsigned j = 0; j < NUM_IDS; j++) begin
         if (!grant_valid && free_hi[j]) begin
            grant_valid = 1'b1;
            grant_id    = SLOT_W'(SLOT_MIN + j);
         end
      end
      for (int unsigned j = 0; j < NUM_IDS; j++) begin
         if (!grant_valid && free_lo[j]) begin
            grant_valid = 1'b1;
            grant_id    = SLOT_W'(SLOT_MIN + j);
         end
      end
   end

endmodule

// File: rtl/game_regfile.sv
// Game datapath register file: 2 read / 1 write ports, hardware-owned
// registers, auto-allocated slot registers and a watched display register.
module game_regfile
   import game_regfile_pkg::*;
#(
   parameter int unsigned                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter logic [(2**ADDR_WIDTH)-1:0]     HW_MASK    = DEF_HW_MASK,
   parameter int unsigned                    SLOT_BASE  = DEF_SLOT_BASE,
   parameter int unsigned                    NUM_SLOTS  = DEF_NUM_SLOTS,
   parameter int unsigned                    SLOT_MIN   = DEF_SLOT_MIN,
   parameter int unsigned                    SLOT_MAX   = DEF_SLOT_MAX,
   parameter int unsigned                    WATCH_ADDR = DEF_WATCH_ADDR
) (
   input  logic                                   clock,
   input  logic                                   ctrl_reset_n,
   input  logic                                   ctrl_writeEnable,
   input  logic [ADDR_WIDTH-1:0]                  ctrl_writeReg,
   input  logic [DATA_WIDTH-1:0]                  data_writeReg,
   input  logic [ADDR_WIDTH-1:0]                  ctrl_readRegA,
   input  logic [ADDR_WIDTH-1:0]                  ctrl_readRegB,
   output logic [DATA_WIDTH-1:0]                  data_readRegA,
   output logic [DATA_WIDTH-1:0]                  data_readRegB,
   input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]  hw_write,
   output logic [NUM_SLOTS*DATA_WIDTH-1:0]        slot_read,
   output logic [DATA_WIDTH-1:0]                  watch_read,
   output logic                                   watch_changed,
   output logic                                   alloc_fail
);

   localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0]       regs [NUM_REGS];
   slot_id_t                    rr_ptr;

   logic                        wr_writable_c;
   logic                        wr_slot_c;
   logic                        wr_alloc_c;
   slot_id_t                    wr_old_field_c;
   logic [DATA_WIDTH-1:0]       wr_value_c;
   logic [DATA_WIDTH-1:0]       watch_next_c;

   logic [NUM_SLOTS*SLOT_W-1:0] slot_fields;
   logic [NUM_SLOTS-1:0]        field_valid;
   logic                        grant_valid;
   slot_id_t                    grant_id;

   // Lanes of registers that are not hardware-owned are deliberately ignored.
   logic                        unused_hw_lanes;
   assign unused_hw_lanes = ^hw_write;

   // Write decode; no CPU write lands (or forwards) while reset is held.
   always_comb begin
      wr_writable_c  = ctrl_reset_n && ctrl_writeEnable &&
                       (ctrl_writeReg != '0) && !HW_MASK[ctrl_writeReg];
      wr_slot_c      = (32'(ctrl_writeReg) >= SLOT_BASE) &&
                       (32'(ctrl_writeReg) <  SLOT_BASE + NUM_SLOTS);
      wr_alloc_c     = wr_writable_c && wr_slot_c &&
                       (data_writeReg[SLOT_W-1:0] > SLOT_W'(SLOT_MAX));
      wr_old_field_c = regs[ctrl_writeReg][SLOT_W-1:0];
   end

   // Value the written register holds after the edge, including allocation.
   always_comb begin
      wr_value_c = data_writeReg;
      if (wr_alloc_c) begin
         wr_value_c[SLOT_W-1:0] = grant_valid ? grant_id : wr_old_field_c;
      end
   end

   // Slot fields presented to the allocator; the writer never blocks itself.
   for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
      assign slot_fields[s*SLOT_W +: SLOT_W] = regs[SLOT_BASE + s][SLOT_W-1:0];
      assign field_valid[s] = (ctrl_writeReg != ADDR_WIDTH'(SLOT_BASE + s));
      assign slot_read[s*DATA_WIDTH +: DATA_WIDTH] = regs[SLOT_BASE + s];
   end

   game_regfile_slot_allocator #(
      .NUM_SLOTS (NUM_SLOTS),
      .SLOT_MIN  (SLOT_MIN),
      .SLOT_MAX  (SLOT_MAX)
   ) u_slot_allocator (
      .slot_fields (slot_fields),
      .field_valid (field_valid),
      .rr_ptr      (rr_ptr),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   // Register storage: r0 tied low, hardware lanes, or CPU-written flops.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (i == 0) begin : g_zero
         assign regs[i] = '0;
      end else if (HW_MASK[i]) begin : g_hw
         logic [DATA_WIDTH-1:0] q;
         // Refresh from the peripheral lane every cycle.
         always_ff @(posedge clock or negedge ctrl_reset_n) begin
            if (!ctrl_reset_n) begin
               q <= '0;
            end else begin
               q <= hw_write[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         assign regs[i] = q;
      end else begin : g_cpu
         logic [DATA_WIDTH-1:0] q;
         // Load on a CPU write addressed to this register.
         always_ff @(posedge clock or negedge ctrl_reset_n) begin
            if (!ctrl_reset_n) begin
               q <= '0;
            end else if (wr_writable_c && (ctrl_writeReg == ADDR_WIDTH'(i))) begin
               q <= wr_value_c;
            end
         end
         assign regs[i] = q;
      end
   end

   // Read ports with write-through forwarding for CPU-writable targets.
   always_comb begin
      data_readRegA = regs[ctrl_readRegA];
      if (ctrl_readRegA == '0) begin
         data_readRegA = '0;
      end else if (wr_writable_c && (ctrl_readRegA == ctrl_writeReg)) begin
         data_readRegA = wr_value_c;
      end

      data_readRegB = regs[ctrl_readRegB];
      if (ctrl_readRegB == '0) begin
         data_readRegB = '0;
      end else if (wr_writable_c && (ctrl_readRegB == ctrl_writeReg)) begin
         data_readRegB = wr_value_c;
      end
   end

   // Value the watched register will hold after the coming edge.
   always_comb begin
      watch_next_c = regs[WATCH_ADDR];
      if ((WATCH_ADDR != 0) && HW_MASK[WATCH_ADDR]) begin
         watch_next_c = hw_write[WATCH_ADDR*DATA_WIDTH +: DATA_WIDTH];
      end else if (wr_writable_c && (ctrl_writeReg == ADDR_WIDTH'(WATCH_ADDR))) begin
         watch_next_c = wr_value_c;
      end
   end

   assign watch_read = regs[WATCH_ADDR];

   // Round-robin pointer plus the change and allocation-failure pulses.
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         rr_ptr        <= SLOT_W'(SLOT_MIN);
         watch_changed <= 1'b0;
         alloc_fail    <= 1'b0;
      end else begin
         watch_changed <= (watch_next_c != regs[WATCH_ADDR]);
         alloc_fail    <= wr_alloc_c && !grant_valid;
         if (wr_alloc_c && grant_valid) begin
            rr_ptr <= rr_advance(grant_id, SLOT_MIN, SLOT_MAX);
         end
      end
   end

endmodule

// File: tb/tb_game_regfile.sv
// Scoreboard bench for game_regfile: a default build plus a 3-slot / 2-id build.
`timescale 1ns/1ps
module tb_game_regfile;

   localparam int unsigned DW = 32;
   localparam int unsigned NR = 32;

   localparam int SIG_RDA   = 0;
   localparam int SIG_RDB   = 1;
   localparam int SIG_WC    = 2;
   localparam int SIG_AF    = 3;
   localparam int SIG_WATCH = 4;
   localparam int SIG_SLOT0 = 5;
   localparam int SIG_SLOT1 = 6;
   localparam int SIG_S_RDA = 7;
   localparam int SIG_S_AF  = 8;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rst_n;

   // Default build
   logic              we;
   logic [4:0]        wr, ra, rb;
   logic [DW-1:0]     wd;
   logic [NR*DW-1:0]  hw;
   logic [DW-1:0]     rd_a, rd_b, watch_rd;
   logic [2*DW-1:0]   slots;
   logic              wc, af;

   // Small build: slots r4..r6 sharing ids 4..5
   logic              s_we;
   logic [4:0]        s_wr, s_ra, s_rb;
   logic [DW-1:0]     s_wd;
   logic [NR*DW-1:0]  s_hw;
   logic [DW-1:0]     s_rd_a, s_unused_rd_b, s_unused_watch;
   logic [3*DW-1:0]   s_unused_slots;
   logic              s_unused_wc, s_af;

   game_regfile dut (
      .clock            (clock),
      .ctrl_reset_n     (rst_n),
      .ctrl_writeEnable (we),
      .ctrl_writeReg    (wr),
      .data_writeReg    (wd),
      .ctrl_readRegA    (ra),
      .ctrl_readRegB    (rb),
      .data_readRegA    (rd_a),
      .data_readRegB    (rd_b),
      .hw_write         (hw),
      .slot_read        (slots),
      .watch_read       (watch_rd),
      .watch_changed    (wc),
      .alloc_fail       (af)
   );

   game_regfile #(
      .HW_MASK   (32'h0000_0100),
      .NUM_SLOTS (3),
      .SLOT_MIN  (4),
      .SLOT_MAX  (5)
   ) dut_small (
      .clock            (clock),
      .ctrl_reset_n     (rst_n),
      .ctrl_writeEnable (s_we),
      .ctrl_writeReg    (s_wr),
      .data_writeReg    (s_wd),
      .ctrl_readRegA    (s_ra),
      .ctrl_readRegB    (s_rb),
      .data_readRegA    (s_rd_a),
      .data_readRegB    (s_unused_rd_b),
      .hw_write         (s_hw),
      .slot_read        (s_unused_slots),
      .watch_read       (s_unused_watch),
      .watch_changed    (s_unused_wc),
      .alloc_fail       (s_af)
   );

   typedef struct {
      string       tag;
      int unsigned cyc;
      int          sig;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   int unsigned cycle = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   always @(posedge clock) cycle <= cycle + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int sig);
      case (sig)
         SIG_RDA:   return rd_a;
         SIG_RDB:   return rd_b;
         SIG_WC:    return 32'(wc);
         SIG_AF:    return 32'(af);
         SIG_WATCH: return watch_rd;
         SIG_SLOT0: return slots[31:0];
         SIG_SLOT1: return slots[63:32];
         SIG_S_RDA: return s_rd_a;
         SIG_S_AF:  return 32'(s_af);
         default:   return 'x;
      endcase
   endfunction

   // Queue an expectation for the sample point dly cycles from now.
   task automatic expect_at(input int unsigned dly, input int sig, input logic [31:0] val,
                            input string tag);
      exp_t e;
      e.tag = tag;
      e.cyc = cycle + dly;
      e.sig = sig;
      e.val = val;
      sb.push_back(e);
   endtask

   // Compare every expectation due in this cycle on the falling edge.
   always @(negedge clock) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cycle) begin
            check_eq(sb[i].tag, observe(sb[i].sig), sb[i].val);
            sb.delete(i);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      we   = 1'b0; wr   = '0; wd   = '0;
      s_we = 1'b0; s_wr = '0; s_wd = '0;
   endtask

   task automatic cpu_wr(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; wr = a; wd = d;
   endtask

   task automatic s_cpu_wr(input logic [4:0] a, input logic [31:0] d);
      s_we = 1'b1; s_wr = a; s_wd = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      ra = '0; rb = '0; s_ra = '0; s_rb = '0;
      hw = '0; s_hw = '0;
      #12 rst_n = 1'b1;
      tick();

      // Reset state
      ra = 5'd4; rb = 5'd9;
      expect_at(0, SIG_RDA, 32'h0, "rst_r4");
      expect_at(0, SIG_RDB, 32'h0, "rst_r9");
      expect_at(0, SIG_WC, 32'h0, "rst_wc");
      expect_at(0, SIG_AF, 32'h0, "rst_af");
      expect_at(0, SIG_WATCH, 32'h0, "rst_watch");
      expect_at(0, SIG_S_AF, 32'h0, "rst_s_af");
      tick();

      // Plain register write with forwarding, and r0
      cpu_wr(5'd10, 32'h1234); ra = 5'd10; rb = 5'd0;
      expect_at(0, SIG_RDA, 32'h1234, "fwd_r10");
      expect_at(0, SIG_RDB, 32'h0, "r0_read");
      tick();
      idle();
      expect_at(0, SIG_RDA, 32'h1234, "r10_held");
      tick();
      cpu_wr(5'd0, 32'd5); ra = 5'd0; rb = 5'd10;
      expect_at(0, SIG_RDA, 32'h0, "r0_no_fwd");
      expect_at(0, SIG_RDB, 32'h1234, "r10_portb");
      tick();
      idle();
      expect_at(0, SIG_RDA, 32'h0, "r0_after_wr");
      tick();

      // Hardware-owned register ignores the CPU
      hw[6*DW +: DW] = 32'd77;
      cpu_wr(5'd6, 32'd1); ra = 5'd6;
      expect_at(0, SIG_RDA, 32'd0, "hw_no_fwd");
      expect_at(1, SIG_RDA, 32'd77, "hw_lane6");
      tick();
      idle();
      hw[6*DW +: DW] = 32'd78;
      expect_at(1, SIG_RDA, 32'd78, "hw_lane6_upd");
      tick();
      tick();

      // Default slot allocation: round-robin over ids 4..9
      cpu_wr(5'd4, 32'hF); ra = 5'd4;
      expect_at(0, SIG_RDA, 32'h4, "alloc_r4_fwd");
      expect_at(1, SIG_SLOT0, 32'h4, "alloc_r4");
      tick();
      cpu_wr(5'd5, 32'hF); ra = 5'd5; rb = 5'd4;
      expect_at(0, SIG_RDA, 32'h5, "alloc_r5_fwd");
      expect_at(0, SIG_RDB, 32'h4, "alloc_r4_portb");
      expect_at(1, SIG_SLOT1, 32'h5, "alloc_r5");
      tick();
      cpu_wr(5'd4, 32'hA0F); ra = 5'd4;
      expect_at(0, SIG_RDA, 32'hA06, "alloc_rr_fwd");
      expect_at(1, SIG_SLOT0, 32'hA06, "alloc_rr");
      expect_at(1, SIG_AF, 32'h0, "alloc_no_fail");
      tick();
      cpu_wr(5'd5, 32'h6);
      expect_at(1, SIG_SLOT1, 32'h6, "slot_dup_ok");
      tick();
      cpu_wr(5'd5, 32'hF);
      expect_at(1, SIG_SLOT1, 32'h7, "alloc_r5_rr7");
      tick();
      cpu_wr(5'd4, 32'hF);
      expect_at(1, SIG_SLOT0, 32'h8, "alloc_r4_rr8");
      tick();
      cpu_wr(5'd4, 32'hF);
      expect_at(1, SIG_SLOT0, 32'h9, "alloc_r4_top");
      tick();
      cpu_wr(5'd4, 32'hF);
      expect_at(1, SIG_SLOT0, 32'h4, "alloc_r4_wrap");
      tick();
      idle();
      tick();

      // Watched register change strobe
      cpu_wr(5'd9, 32'd3);
      expect_at(0, SIG_WC, 32'h0, "wc_idle");
      expect_at(1, SIG_WC, 32'h1, "wc_first");
      expect_at(1, SIG_WATCH, 32'd3, "watch_val");
      tick();
      cpu_wr(5'd9, 32'd3);
      expect_at(1, SIG_WC, 32'h0, "wc_same");
      tick();
      cpu_wr(5'd9, 32'd4);
      expect_at(1, SIG_WC, 32'h1, "wc_third");
      tick();
      idle();
      expect_at(1, SIG_WC, 32'h0, "wc_drop");
      tick();
      tick();

      // Small build: self exclusion, self reuse and exhaustion
      s_cpu_wr(5'd4, 32'd4);
      tick();
      s_cpu_wr(5'd5, 32'd5);
      tick();
      s_cpu_wr(5'd4, 32'hF); s_ra = 5'd4;
      expect_at(0, SIG_S_RDA, 32'h4, "self_excl_r4");
      expect_at(1, SIG_S_AF, 32'h0, "self_excl_nofail");
      tick();
      s_cpu_wr(5'd5, 32'hF); s_ra = 5'd5;
      expect_at(0, SIG_S_RDA, 32'h5, "self_keep_r5");
      tick();
      s_cpu_wr(5'd4, 32'd5);
      tick();
      s_cpu_wr(5'd4, 32'hF); s_ra = 5'd4;
      expect_at(0, SIG_S_RDA, 32'h4, "dup_pre_r4");
      tick();
      s_cpu_wr(5'd4, 32'hF);
      expect_at(0, SIG_S_RDA, 32'h4, "self_reuse");
      expect_at(1, SIG_S_AF, 32'h0, "self_reuse_nofail");
      tick();
      s_cpu_wr(5'd6, 32'd4);
      tick();
      s_cpu_wr(5'd6, 32'hB0F); s_ra = 5'd6;
      expect_at(0, SIG_S_RDA, 32'hB04, "fail_fwd");
      expect_at(1, SIG_S_AF, 32'h1, "fail_pulse");
      expect_at(1, SIG_S_RDA, 32'hB04, "fail_keep_field");
      expect_at(2, SIG_S_AF, 32'h0, "fail_one_cycle");
      tick();
      idle();
      tick();
      tick();

      // Asynchronous reset in the middle of a failing allocation and a watch change
      s_cpu_wr(5'd6, 32'hF); s_ra = 5'd6;
      cpu_wr(5'd9, 32'd7); ra = 5'd10; rb = 5'd4;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_async_a", rd_a, 32'h0);
      check_eq("rst_async_b", rd_b, 32'h0);
      check_eq("rst_async_watch", watch_rd, 32'h0);
      check_eq("rst_async_s_fwd", s_rd_a, 32'h0);
      check_eq("rst_async_s_af", 32'(s_af), 32'h0);
      idle();
      @(posedge clock);
      #3 rst_n = 1'b1;
      tick();
      expect_at(0, SIG_WC, 32'h0, "no_wc_after_rst");
      expect_at(0, SIG_S_AF, 32'h0, "no_af_after_rst");
      expect_at(1, SIG_WC, 32'h0, "no_wc_after_rst2");
      expect_at(1, SIG_S_AF, 32'h0, "no_af_after_rst2");
      expect_at(0, SIG_RDA, 32'h0, "r10_cleared");
      tick();
      tick();
      tick();

      check_eq("sb_drain", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
